// File: rtl/uartcon_tx_param.sv
// Parametrised UART transmitter: one word per valid/load handshake, LSB first,
// configurable frame size, bit period, parity and stop bits, with line BREAK support.
module uartcon_tx_param #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 txd,
  input  logic                 valid,
  output logic                 load,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 brk,
  output logic                 busy
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DBIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [DBIT_W-1:0] DBIT_LAST = DBIT_W'(DATA_BITS - 1);
  localparam logic              SBIT_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DBIT_W-1:0]    dbit;
  logic                 sbit;
  logic [DATA_BITS-1:0] shift;
  logic                 par;

  logic tick;
  logic accept_slot;
  logic data_par;

  assign tick = (bit_cnt == CNT_LAST);

  // A new frame or a BREAK may begin only from idle or on the last stop tick.
  assign accept_slot = (state == S_IDLE) ||
                       ((state == S_STOP) && tick && (sbit == SBIT_LAST));

  assign data_par = (PARITY == 1) ? ~^data : ^data;

  // Bit timer is held at zero while idle or in BREAK so the following period starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (state == S_IDLE || state == S_BREAK || tick) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      txd   <= 1'b1;
      load  <= 1'b0;
      busy  <= 1'b0;
      dbit  <= '0;
      sbit  <= 1'b0;
      shift <= '0;
      par   <= 1'b0;
    end else begin
      load <= 1'b0;
      if (accept_slot && brk) begin
        state <= S_BREAK;
        txd   <= 1'b0;
        busy  <= 1'b1;
        sbit  <= 1'b0;
      end else if (accept_slot && valid) begin
        state <= S_START;
        shift <= data;
        par   <= data_par;
        load  <= 1'b1;
        txd   <= 1'b0;
        busy  <= 1'b1;
        sbit  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            txd  <= 1'b1;
            busy <= 1'b0;
          end
          S_START: begin
            if (tick) begin
              txd   <= shift[0];
              dbit  <= '0;
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (tick) begin
              if (dbit == DBIT_LAST) begin
                dbit <= '0;
                if (PARITY != 0) begin
                  state <= S_PARITY;
                  txd   <= par;
                end else begin
                  state <= S_STOP;
                  txd   <= 1'b1;
                  sbit  <= 1'b0;
                end
              end else begin
                dbit  <= dbit + DBIT_W'(1);
                shift <= shift >> 1;
                txd   <= shift[1];
              end
            end
          end
          S_PARITY: begin
            if (tick) begin
              state <= S_STOP;
              txd   <= 1'b1;
              sbit  <= 1'b0;
            end
          end
          S_STOP: begin
            if (tick) begin
              if (sbit == SBIT_LAST) begin
                state <= S_IDLE;
                txd   <= 1'b1;
                busy  <= 1'b0;
                sbit  <= 1'b0;
              end else begin
                sbit <= 1'b1;
              end
            end
          end
          S_BREAK: begin
            if (!brk) begin
              state <= S_STOP;
              txd   <= 1'b1;
              sbit  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uartcon_tx_param.sv
// Directed bench for uartcon_tx_param: four parameterisations checked cycle by cycle
// against hand-derived frame waveforms.
module tb_uartcon_tx_param;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_bus;
  logic [3:0] valid_v;
  logic [3:0] brk_v;
  logic [3:0] txd_v;
  logic [3:0] load_v;
  logic [3:0] busy_v;

  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults 8N2, 1: even parity 1 stop, 2: odd parity 1 stop, 3: 5 data bits at 16 clks/bit
  uartcon_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_def (
    .clk(clk), .rst_n(rst_n), .txd(txd_v[0]), .valid(valid_v[0]), .load(load_v[0]),
    .data(data_bus), .brk(brk_v[0]), .busy(busy_v[0]));

  uartcon_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .txd(txd_v[1]), .valid(valid_v[1]), .load(load_v[1]),
    .data(data_bus), .brk(brk_v[1]), .busy(busy_v[1]));

  uartcon_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .txd(txd_v[2]), .valid(valid_v[2]), .load(load_v[2]),
    .data(data_bus), .brk(brk_v[2]), .busy(busy_v[2]));

  uartcon_tx_param #(.CLKS_PER_BIT(16), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_short (
    .clk(clk), .rst_n(rst_n), .txd(txd_v[3]), .valid(valid_v[3]), .load(load_v[3]),
    .data(data_bus[4:0]), .brk(brk_v[3]), .busy(busy_v[3]));

  // Raise valid for one accept edge; returns at the negedge of frame sample 0.
  task automatic start_frame(input int idx, input logic [7:0] word);
    @(negedge clk);
    data_bus     = word;
    valid_v[idx] = 1'b1;
    @(posedge clk);
    #1 valid_v[idx] = 1'b0;
    @(negedge clk);
  endtask

  // Called at sample 0 of a frame; checks every clock against the expected waveform.
  task automatic check_frame(input int idx, input logic [7:0] word, input int dbits,
                             input int cpb, input int has_par, input logic exp_par,
                             input int stops, input bit check_end, input string name);
    int   total;
    int   b;
    logic exp_txd;
    logic exp_load;
    total = (1 + dbits + has_par + stops) * cpb;
    for (int k = 0; k < total; k++) begin
      b = k / cpb;
      if (b == 0) exp_txd = 1'b0;
      else if (b <= dbits) exp_txd = word[b-1];
      else if (has_par != 0 && b == dbits + 1) exp_txd = exp_par;
      else exp_txd = 1'b1;
      exp_load = (k == 0);
      tests++;
      if (txd_v[idx] !== exp_txd) begin
        fails++;
        $display("FAIL %s txd clk %0d: got %b expected %b", name, k, txd_v[idx], exp_txd);
      end
      tests++;
      if (load_v[idx] !== exp_load) begin
        fails++;
        $display("FAIL %s load clk %0d: got %b expected %b", name, k, load_v[idx], exp_load);
      end
      tests++;
      if (busy_v[idx] !== 1'b1) begin
        fails++;
        $display("FAIL %s busy clk %0d: got %b expected 1", name, k, busy_v[idx]);
      end
      @(negedge clk);
    end
    if (check_end) begin
      tests++;
      if (busy_v[idx] !== 1'b0 || txd_v[idx] !== 1'b1 || load_v[idx] !== 1'b0) begin
        fails++;
        $display("FAIL %s end-of-frame busy/txd/load: got %b%b%b expected 010",
                 name, busy_v[idx], txd_v[idx], load_v[idx]);
      end
    end
  endtask

  task automatic test_reset;
    #12;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (txd_v[i] !== 1'b1) begin
        fails++;
        $display("FAIL reset txd[%0d]: got %b expected 1", i, txd_v[i]);
      end
      tests++;
      if (load_v[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset load[%0d]: got %b expected 0", i, load_v[i]);
      end
      tests++;
      if (busy_v[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset busy[%0d]: got %b expected 0", i, busy_v[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (txd_v !== 4'hF || busy_v !== 4'h0 || load_v !== 4'h0) begin
        fails++;
        $display("FAIL idle after reset txd/busy/load: got %h/%h/%h expected f/0/0",
                 txd_v, busy_v, load_v);
      end
    end
  endtask

  task automatic test_default_frame;
    start_frame(0, 8'h55);
    check_frame(0, 8'h55, 8, 4, 0, 1'b0, 2, 1'b1, "dflt_55");
  endtask

  task automatic test_parity;
    start_frame(1, 8'h07);
    check_frame(1, 8'h07, 8, 4, 1, 1'b1, 1, 1'b1, "even_07");
    start_frame(2, 8'h07);
    check_frame(2, 8'h07, 8, 4, 1, 1'b0, 1, 1'b1, "odd_07");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    data_bus   = 8'hA5;
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1 data_bus = 8'h3C;
    fork
      begin
        repeat (44) @(posedge clk);
        #1 valid_v[0] = 1'b0;
      end
    join_none
    @(negedge clk);
    check_frame(0, 8'hA5, 8, 4, 0, 1'b0, 2, 1'b0, "b2b_A5");
    check_frame(0, 8'h3C, 8, 4, 0, 1'b0, 2, 1'b1, "b2b_3C");
  endtask

  task automatic test_break;
    @(negedge clk);
    data_bus   = 8'h96;
    valid_v[0] = 1'b1;
    brk_v[0]   = 1'b1;
    fork
      begin
        repeat (20) @(posedge clk);
        #1 brk_v[0] = 1'b0;
      end
      begin
        repeat (29) @(posedge clk);
        #1 valid_v[0] = 1'b0;
      end
    join_none
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      tests++;
      if (txd_v[0] !== (k >= 20) || load_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
        fails++;
        $display("FAIL break clk %0d txd/load/busy: got %b%b%b expected %b01",
                 k, txd_v[0], load_v[0], busy_v[0], (k >= 20));
      end
    end
    @(negedge clk);
    check_frame(0, 8'h96, 8, 4, 0, 1'b0, 2, 1'b1, "after_brk_96");
  endtask

  task automatic test_short_frame;
    start_frame(3, 8'h1F);
    check_frame(3, 8'h1F, 5, 16, 0, 1'b0, 2, 1'b1, "short_1F");
  endtask

  task automatic test_reset_mid_frame;
    start_frame(0, 8'h55);
    repeat (17) @(negedge clk);
    tests++;
    if (txd_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL pre-reset data bit3 txd/busy: got %b%b expected 01", txd_v[0], busy_v[0]);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || load_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL async reset txd/busy/load: got %b%b%b expected 100",
               txd_v[0], busy_v[0], load_v[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_frame(0, 8'hC3);
    check_frame(0, 8'hC3, 8, 4, 0, 1'b0, 2, 1'b1, "post_reset_C3");
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    data_bus = 8'h00;
    valid_v  = 4'h0;
    brk_v    = 4'h0;
    test_reset();
    test_default_frame();
    test_parity();
    test_back_to_back();
    test_break();
    test_short_frame();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
